// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port req/gnt/rvalid arbiter in front of a single-port synchronous RAM
//
// Optional build macro: ARB_FIXED_PRIORITY_EN
//   defined   : port 0 always wins a tie (port 1 may starve)
//   undefined : round-robin tie break using last_grant
//
// Access sequence: IDLE -> GRANT -> (write) IDLE
//                  IDLE -> GRANT -> WAIT x READ_LATENCY -> RESP -> IDLE
// Every output is a flop. The values loaded on each edge are decoded from
// the current state and inputs, so gnt/mem_en appear in the cycle right
// after the request is sampled.

module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    // Counter reload value: WAIT lasts READ_LATENCY cycles (counts down to 0).
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Access bookkeeping latched when a request is accepted.
    logic       winner;     // 0: port 0 owns the access, 1: port 1
    logic       lat_we;     // latched write/read of the accepted request
    logic [2:0] count;      // remaining WAIT cycles before mem_rdata is valid

    // Arbitration decode.
    logic any_req;
    logic tie_pick;
    logic sel;
    logic sel_we;
    logic take;
    logic done_wait;

    // Next values for the registered outputs.
    logic                  gnt0_nxt;
    logic                  gnt1_nxt;
    logic                  rvalid0_nxt;
    logic                  rvalid1_nxt;
    logic                  mem_en_nxt;
    logic                  mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  busy_nxt;

`ifdef ARB_FIXED_PRIORITY_EN
    // Port 0 has precedence on every tie.
    assign tie_pick = 1'b0;
`else
    // Port that did not win last time gets the tie; reset value makes port 0 win first.
    logic last_grant;
    assign tie_pick = ~last_grant;
`endif

    assign any_req   = req0 | req1;
    assign sel       = (req0 && req1) ? tie_pick : req1;
    assign sel_we    = sel ? we1 : we0;
    assign take      = (state == IDLE) && any_req;
    assign done_wait = (state == WAIT) && (count == 3'd0);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   state_nxt = lat_we ? IDLE : WAIT;
            WAIT:    if (count == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: values the output flops take on the coming edge
    always_comb begin
        gnt0_nxt      = take && !sel;
        gnt1_nxt      = take && sel;
        mem_en_nxt    = take;
        mem_we_nxt    = take && sel_we;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        if (take) begin
            mem_addr_nxt  = sel ? addr1  : addr0;
            mem_wdata_nxt = sel ? wdata1 : wdata0;
        end
        rvalid0_nxt   = done_wait && !winner;
        rvalid1_nxt   = done_wait && winner;
        busy_nxt      = (state_nxt != IDLE);
    end

    // Access bookkeeping: winner, latched direction, latency countdown, round-robin history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            winner <= 1'b0;
            lat_we <= 1'b0;
            count  <= 3'd0;
`ifdef ARB_FIXED_PRIORITY_EN
`else
            last_grant <= 1'b1;
`endif
        end else begin
            if (take) begin
                winner <= sel;
                lat_we <= sel_we;
`ifdef ARB_FIXED_PRIORITY_EN
`else
                last_grant <= sel;
`endif
            end
            if (state == GRANT) begin
                count <= LAT_LOAD;
            end else if ((state == WAIT) && (count != 3'd0)) begin
                count <= count - 3'd1;
            end
        end
    end

    // Output flops; read data is captured on the last WAIT cycle and held until the next read on that port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            rvalid0   <= rvalid0_nxt;
            rvalid1   <= rvalid1_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
            if (done_wait && !winner) begin
                rdata0 <= mem_rdata;
            end
            if (done_wait && winner) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (READ_LATENCY 1 and 3)

module tb_mem_arbiter;

    logic        clock;
    logic        reset;

    // Instance a: READ_LATENCY = 1
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // Instance b: READ_LATENCY = 3
    logic        b_req0, b_we0, b_req1, b_we1;
    logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1;
    logic        b_gnt0, b_rvalid0, b_gnt1, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_seq;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM models: read data is only meaningful in the exact latency cycle, poison otherwise
    logic [31:0] ram_a [0:255];
    logic [31:0] pipe_a;
    logic        v_a = 1'b0;
    always @(posedge clock) begin
        if (mem_en && mem_we) ram_a[mem_addr[7:0]] <= mem_wdata;
        pipe_a <= ram_a[mem_addr[7:0]];
        v_a    <= mem_en && !mem_we;
    end
    assign mem_rdata = v_a ? pipe_a : 32'hBAD0_BAD0;

    logic [31:0] ram_b [0:255];
    logic [31:0] pipe_b0, pipe_b1, pipe_b2;
    logic        v_b0 = 1'b0, v_b1 = 1'b0, v_b2 = 1'b0;
    always @(posedge clock) begin
        if (b_mem_en && b_mem_we) ram_b[b_mem_addr[7:0]] <= b_mem_wdata;
        pipe_b0 <= ram_b[b_mem_addr[7:0]];
        v_b0    <= b_mem_en && !b_mem_we;
        pipe_b1 <= pipe_b0;
        v_b1    <= v_b0;
        pipe_b2 <= pipe_b1;
        v_b2    <= v_b1;
    end
    assign b_mem_rdata = v_b2 ? pipe_b2 : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef ARB_FIXED_PRIORITY_EN
        exp_seq = 4'b0000;
`else
        exp_seq = 4'b1010;
`endif
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
        b_req1 = 0; b_we1 = 0; b_addr1 = 0; b_wdata1 = 0;
        repeat (2) tick();
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata0", rdata0, 0);
        reset = 1'b0;
        tick();

        // Single write
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        tick();
        chk("wr_gnt0", 32'(gnt0), 1);
        chk("wr_gnt1", 32'(gnt1), 0);
        chk("wr_mem_en", 32'(mem_en), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("wr_busy", 32'(busy), 1);
        req0 = 0; we0 = 0;
        tick();
        chk("wr_busy_fall", 32'(busy), 0);
        chk("wr_mem_en_fall", 32'(mem_en), 0);
        chk("wr_no_rvalid", 32'(rvalid0), 0);

        // Preload 0x20 then read it back
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
        tick();
        chk("pre_gnt0", 32'(gnt0), 1);
        req0 = 0; we0 = 0;
        tick();
        req0 = 1; addr0 = 32'h20;
        tick();
        chk("rd_gnt0", 32'(gnt0), 1);
        chk("rd_mem_en", 32'(mem_en), 1);
        chk("rd_mem_we", 32'(mem_we), 0);
        chk("rd_mem_addr", mem_addr, 32'h20);
        req0 = 0;
        tick();
        chk("rd_t2_rvalid", 32'(rvalid0), 0);
        chk("rd_t2_mem_en", 32'(mem_en), 0);
        chk("rd_t2_busy", 32'(busy), 1);
        tick();
        chk("rd_t3_rvalid0", 32'(rvalid0), 1);
        chk("rd_t3_rdata0", rdata0, 32'h1234_5678);
        chk("rd_t3_rvalid1", 32'(rvalid1), 0);
        tick();
        chk("rd_t4_rvalid0", 32'(rvalid0), 0);
        chk("rd_t4_busy", 32'(busy), 0);
        chk("rd_t4_hold", rdata0, 32'h1234_5678);

        // Contention from a fresh reset: both ports keep writing
        reset = 1'b1; #2; reset = 1'b0;
        req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'hA0;
        req1 = 1; we1 = 1; addr1 = 32'h50; wdata1 = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("arb%0d_gnt0", i), 32'(gnt0), 32'(!exp_seq[i]));
            chk($sformatf("arb%0d_gnt1", i), 32'(gnt1), 32'(exp_seq[i]));
            chk($sformatf("arb%0d_addr", i), mem_addr, exp_seq[i] ? 32'h50 : 32'h40);
            tick();
            chk($sformatf("arb%0d_gap", i), 32'(gnt0 | gnt1), 0);
        end
        req0 = 0; we0 = 0;
        tick();
        chk("solo1_gnt1", 32'(gnt1), 1);
        chk("solo1_gnt0", 32'(gnt0), 0);
        req1 = 0; we1 = 0;
        tick();

        // Reset during WAIT
        req0 = 1; we0 = 0; addr0 = 32'h20;
        tick();
        chk("rw_gnt0", 32'(gnt0), 1);
        req0 = 0;
        tick();
        reset = 1'b1;
        #1;
        chk("rw_busy", 32'(busy), 0);
        chk("rw_mem_en", 32'(mem_en), 0);
        chk("rw_rdata0", rdata0, 0);
        chk("rw_rvalid0", 32'(rvalid0), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rw_quiet%0d", i), 32'({rvalid0, busy}), 0);
        end
        req0 = 1; addr0 = 32'h20;
        tick();
        chk("rw_regrant", 32'(gnt0), 1);
        req0 = 0;
        tick();
        tick();
        chk("rw_rvalid0", 32'(rvalid0), 1);
        chk("rw_rdata0_after", rdata0, 32'h1234_5678);
        tick();

        // Withdrawn request never sampled
        req1 = 1; #3; req1 = 0;
        tick();
        chk("wd_gnt1", 32'(gnt1), 0);
        chk("wd_mem_en", 32'(mem_en), 0);
        chk("wd_busy", 32'(busy), 0);

        // READ_LATENCY = 3 on port 1
        b_req1 = 1; b_we1 = 1; b_addr1 = 32'h30; b_wdata1 = 32'hA5A5_5A5A;
        tick();
        chk("l3_wr_gnt1", 32'(b_gnt1), 1);
        b_req1 = 0; b_we1 = 0;
        tick();
        b_req1 = 1;
        tick();
        chk("l3_gnt1", 32'(b_gnt1), 1);
        chk("l3_mem_en", 32'(b_mem_en), 1);
        b_req1 = 0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("l3_t%0d_quiet", i), 32'({b_rvalid1, b_mem_en}), 0);
        end
        tick();
        chk("l3_t5_rvalid1", 32'(b_rvalid1), 1);
        chk("l3_t5_rdata1", b_rdata1, 32'hA5A5_5A5A);
        chk("l3_t5_rvalid0", 32'(b_rvalid0), 0);
        tick();
        chk("l3_t6_rvalid1", 32'(b_rvalid1), 0);
        chk("l3_t6_busy", 32'(b_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
